// File: rtl/reg_pkg.sv
// Shared register-file types and defaults for the write-enable decoder and
// the in-flight write scoreboard.
package reg_pkg;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT   = $clog2(NUM_REGS_DEFAULT);
  localparam int CNT_W_DEFAULT    = 2;

  typedef logic [ADDR_W_DEFAULT-1:0]   reg_addr_t;
  typedef logic [NUM_REGS_DEFAULT-1:0] reg_onehot_t;

endpackage

// File: rtl/reg_onehot_decode.sv
// Combinational register-address to one-hot decoder with an enable; an
// all-zero vector is produced when the enable is low.
module reg_onehot_decode #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_write_scoreboard.sv
// Registered one-hot write-enable decode plus per-register in-flight write
// counters. Optional feature macro: ZERO_REG_EN (register ZERO_REG never counted).
module reg_write_scoreboard
  import reg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int ZERO_REG = NUM_REGS - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_wr,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                wb_valid,
  input  logic                wb_wr,
  input  logic [ADDR_W-1:0]   wb_rd,
  output logic [NUM_REGS-1:0] wb_en,
  output logic                underflow_err
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic                issue_is_zero;
  logic                wb_is_zero;
  logic                issue_fire;
  logic                issue_count;
  logic                wb_fire;
  logic                wb_count;
  logic                wb_to_issue_rd;
  logic                underflow_d;
  logic [NUM_REGS-1:0] wb_en_d;

  assign issue_is_zero = ZERO_EN && (issue_rd == ZERO_ADDR);
  assign wb_is_zero    = ZERO_EN && (wb_rd == ZERO_ADDR);

  // Handshake: issue fires when issue_valid && issue_ready in the same cycle;
  // issue_ready never depends on issue_valid, and a full counter only stalls
  // a writing instruction unless a writeback frees its slot this cycle.
  assign wb_fire        = wb_valid && wb_wr;
  assign wb_to_issue_rd = wb_fire && (wb_rd == issue_rd);
  assign issue_ready    = !(issue_wr && (cnt[issue_rd] == CNT_MAX)) || wb_to_issue_rd;
  assign issue_fire     = issue_valid && issue_ready;

  assign issue_count = issue_fire && issue_wr && !issue_is_zero;
  assign wb_count    = wb_fire && !wb_is_zero;

  assign rs1_busy = (cnt[rs1] != '0);
  assign rs2_busy = (cnt[rs2] != '0);

  // A writeback with nothing pending is an upstream protocol error; the
  // count holds at zero and the sticky flag records it.
  assign underflow_d = wb_count && (cnt[wb_rd] == '0);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] cnt_q;

    assign inc = issue_count && (issue_rd == ADDR_W'(r));
    assign dec = wb_count && (wb_rd == ADDR_W'(r));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        case ({inc, dec})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    assign cnt[r] = cnt_q;
  end

  reg_onehot_decode #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_wb_decode (
    .en     (wb_count),
    .addr   (wb_rd),
    .onehot (wb_en_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en         <= '0;
      underflow_err <= 1'b0;
    end else begin
      wb_en <= wb_en_d;
      if (underflow_d) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard with hand-computed expectations.
module tb_reg_write_scoreboard;
  import reg_pkg::*;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_wr;
  reg_addr_t   issue_rd;
  logic        issue_ready;
  reg_addr_t   rs1;
  reg_addr_t   rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wb_valid;
  logic        wb_wr;
  reg_addr_t   wb_rd;
  reg_onehot_t wb_en;
  logic        underflow_err;

  int n_cmp = 0;
  int n_err = 0;

  reg_write_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_wr      (issue_wr),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .wb_valid      (wb_valid),
    .wb_wr         (wb_wr),
    .wb_rd         (wb_rd),
    .wb_en         (wb_en),
    .underflow_err (underflow_err)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge; inputs change and outputs are sampled
  // well away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_wr = 1'b0; wb_rd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic drive_issue(input reg_addr_t rd);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd;
  endtask

  task automatic drive_wb(input reg_addr_t rd);
    wb_valid = 1'b1; wb_wr = 1'b1; wb_rd = rd;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_en(input string name, input reg_onehot_t exp);
    n_cmp++;
    if (wb_en !== exp) begin
      n_err++;
      $display("FAIL %s: wb_en got %h expected %h", name, wb_en, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
    wb_valid = 1'b1; wb_wr = 1'b1; wb_rd = 5'd4;
    rs1 = 5'd3; rs2 = 5'd4;
    #3;
    chk_en("reset_wb_en", '0);
    chk1("reset_ready", issue_ready, 1'b1);
    chk1("reset_rs1_busy", rs1_busy, 1'b0);
    chk1("reset_rs2_busy", rs2_busy, 1'b0);
    chk1("reset_underflow", underflow_err, 1'b0);
    tick(); tick();
    chk1("reset_held_rs1_busy", rs1_busy, 1'b0);
    chk_en("reset_held_wb_en", '0);
    idle_inputs();
    reset = 1'b0;
    tick();
    drive_wb(5'd5);
    tick();
    idle_inputs();
    #1;
    chk_en("wb_r5_pulse", 32'h0000_0020);
    tick();
    chk_en("wb_r5_pulse_end", '0);
    do_reset();
  endtask

  task automatic test_saturate();
    rs1 = 5'd3; rs2 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      drive_issue(5'd3);
      #1;
      chk1($sformatf("sat_ready_%0d", i), issue_ready, 1'b1);
      tick();
    end
    #1;
    chk1("sat_full_not_ready", issue_ready, 1'b0);
    chk1("sat_rs1_busy", rs1_busy, 1'b1);
    tick();
    drive_wb(5'd3);
    #1;
    chk1("sat_ready_with_wb", issue_ready, 1'b1);
    tick();
    wb_valid = 1'b0; wb_wr = 1'b0;
    #1;
    chk_en("sat_wb_en_r3", 32'h0000_0008);
    chk1("sat_count_still_3", issue_ready, 1'b0);
    issue_valid = 1'b0;
    issue_wr = 1'b0;
    #1;
    chk1("sat_no_wr_ready", issue_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_wb(5'd3);
      tick();
    end
    idle_inputs();
    #1;
    chk1("sat_drained_busy", rs1_busy, 1'b0);
    chk1("sat_no_underflow", underflow_err, 1'b0);
  endtask

  task automatic test_hazard();
    rs1 = 5'd7; rs2 = 5'd8;
    drive_issue(5'd7);
    #1;
    chk1("haz_same_cycle_busy", rs1_busy, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk1("haz_rs1_busy", rs1_busy, 1'b1);
    chk1("haz_rs2_idle", rs2_busy, 1'b0);
    drive_wb(5'd7);
    #1;
    chk1("haz_busy_during_wb", rs1_busy, 1'b1);
    tick();
    idle_inputs();
    #1;
    chk1("haz_rs1_cleared", rs1_busy, 1'b0);
    chk_en("haz_wb_en_r7", 32'h0000_0080);
  endtask

  task automatic test_back_to_back();
    rs1 = 5'd10; rs2 = 5'd12;
    drive_issue(5'd10); tick();
    drive_issue(5'd11); tick();
    drive_issue(5'd12); drive_wb(5'd10); tick();
    issue_valid = 1'b0; issue_wr = 1'b0;
    drive_wb(5'd11);
    #1;
    chk_en("b2b_first", 32'h0000_0400);
    chk1("b2b_r10_free", rs1_busy, 1'b0);
    chk1("b2b_r12_busy", rs2_busy, 1'b1);
    tick();
    drive_wb(5'd12);
    #1;
    chk_en("b2b_second", 32'h0000_0800);
    tick();
    idle_inputs();
    #1;
    chk_en("b2b_third", 32'h0000_1000);
    chk1("b2b_r12_free", rs2_busy, 1'b0);
    tick();
    chk_en("b2b_idle", '0);
    chk1("b2b_no_underflow", underflow_err, 1'b0);
  endtask

  task automatic test_underflow();
    rs1 = 5'd9; rs2 = 5'd0;
    drive_wb(5'd9);
    #1;
    chk1("uf_not_yet", underflow_err, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk1("uf_set", underflow_err, 1'b1);
    chk1("uf_cnt_zero", rs1_busy, 1'b0);
    tick(); tick(); tick();
    chk1("uf_sticky", underflow_err, 1'b1);
    drive_issue(5'd9); tick();
    idle_inputs(); #1;
    chk1("uf_cnt_one_after_issue", rs1_busy, 1'b1);
    drive_wb(5'd9); tick();
    idle_inputs(); #1;
    chk1("uf_cnt_back_zero", rs1_busy, 1'b0);
  endtask

  task automatic test_mid_reset();
    rs1 = 5'd1; rs2 = 5'd2;
    drive_issue(5'd1); tick();
    drive_issue(5'd1); tick();
    drive_issue(5'd2); tick();
    issue_rd = 5'd1;
    #1;
    chk1("mr_r1_busy", rs1_busy, 1'b1);
    chk1("mr_r2_busy", rs2_busy, 1'b1);
    reset = 1'b1;
    #1;
    chk1("mr_r1_cleared", rs1_busy, 1'b0);
    chk1("mr_r2_cleared", rs2_busy, 1'b0);
    chk1("mr_ready", issue_ready, 1'b1);
    chk1("mr_underflow_cleared", underflow_err, 1'b0);
    idle_inputs();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_zero_reg();
    reg_onehot_t exp_en;
    logic        exp_busy;
`ifdef ZERO_REG_EN
    exp_en   = '0;
    exp_busy = 1'b0;
`else
    exp_en   = 32'h8000_0000;
    exp_busy = 1'b1;
`endif
    rs1 = 5'd31; rs2 = 5'd31;
    drive_issue(5'd31); tick();
    idle_inputs(); #1;
    chk1("zr_rs1_busy", rs1_busy, exp_busy);
    chk1("zr_rs2_busy", rs2_busy, exp_busy);
    drive_wb(5'd31); tick();
    idle_inputs(); #1;
    chk_en("zr_wb_en", exp_en);
    chk1("zr_busy_after_wb", rs1_busy, 1'b0);
    chk1("zr_no_underflow", underflow_err, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    rs1 = '0; rs2 = '0;
    test_reset();
    test_saturate();
    test_hazard();
    test_back_to_back();
    test_underflow();
    test_mid_reset();
    test_zero_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
